// File: rtl/demux12_router.sv
// demux12_router: 1-to-2 valid/ready demultiplexer with a one-entry holding
// register per output channel and a wrapping transfer counter per channel.
module demux12_router #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      state0;
    chan_state_t      state1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [CNT_W-1:0] count0;
    logic [CNT_W-1:0] count1;

    logic in_xfer;
    logic load0;
    logic load1;
    logic drain0;
    logic drain1;

    // Valid comes straight from the channel state, so it never sees a ready input.
    assign out0_valid = (state0 == FULL);
    assign out1_valid = (state1 == FULL);
    assign out0_data  = data0;
    assign out1_data  = data1;
    assign cnt0       = count0;
    assign cnt1       = count1;

    always_comb begin
        in_ready = 1'b0;
        if (in_select) begin
            in_ready = !out1_valid || out1_ready;
        end else begin
            in_ready = !out0_valid || out0_ready;
        end
    end

    assign in_xfer = in_valid && in_ready;
    assign load0   = in_xfer && !in_select;
    assign load1   = in_xfer && in_select;
    assign drain0  = out0_valid && out0_ready;
    assign drain1  = out1_valid && out1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state0 <= EMPTY;
            data0  <= '0;
            count0 <= '0;
        end else begin
            case (state0)
                EMPTY: begin
                    if (load0) begin
                        state0 <= FULL;
                        data0  <= in_data;
                    end
                end
                FULL: begin
                    // A drain and a load in the same cycle keeps the channel full with the new word.
                    if (load0) begin
                        data0 <= in_data;
                    end else if (drain0) begin
                        state0 <= EMPTY;
                    end
                end
                default: state0 <= EMPTY;
            endcase
            if (drain0) begin
                count0 <= count0 + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state1 <= EMPTY;
            data1  <= '0;
            count1 <= '0;
        end else begin
            case (state1)
                EMPTY: begin
                    if (load1) begin
                        state1 <= FULL;
                        data1  <= in_data;
                    end
                end
                FULL: begin
                    if (load1) begin
                        data1 <= in_data;
                    end else if (drain1) begin
                        state1 <= EMPTY;
                    end
                end
                default: state1 <= EMPTY;
            endcase
            if (drain1) begin
                count1 <= count1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux12_router.sv
// tb_demux12_router: directed and randomized checks of demux12_router against
// a queue-based model of the two holding channels.
module tb_demux12_router;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_select = 1'b0;
    logic             out0_valid;
    logic             out0_ready = 1'b0;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready = 1'b0;
    logic [WIDTH-1:0] out1_data;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int n_compared = 0;
    int n_mismatched = 0;
    bit check_en = 1'b0;

    demux12_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_select  (in_select),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    // Model: words accepted but not yet delivered, per channel, in arrival order.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [CNT_W-1:0] m_cnt0 = '0;
    logic [CNT_W-1:0] m_cnt1 = '0;
    int               accepted = 0;
    int               drained = 0;
    bit               m_d0, m_d1, m_acc;

    function automatic bit model_ready();
        if (in_select) return (q1.size() == 0) || out1_ready;
        return (q0.size() == 0) || out0_ready;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_cnt0 = '0;
            m_cnt1 = '0;
        end else begin
            m_d0  = (q0.size() > 0) && out0_ready;
            m_d1  = (q1.size() > 0) && out1_ready;
            m_acc = in_valid && model_ready();
            if (m_d0) begin
                void'(q0.pop_front());
                m_cnt0 = m_cnt0 + 1'b1;
                drained++;
            end
            if (m_d1) begin
                void'(q1.pop_front());
                m_cnt1 = m_cnt1 + 1'b1;
                drained++;
            end
            if (m_acc) begin
                if (in_select) q1.push_back(in_data);
                else q0.push_back(in_data);
                accepted++;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("in_ready", in_ready, model_ready());
            check("out0_valid", out0_valid, q0.size() > 0);
            check("out1_valid", out1_valid, q1.size() > 0);
            if (q0.size() > 0) check("out0_data", out0_data, q0[0]);
            if (q1.size() > 0) check("out1_data", out1_data, q1[0]);
            check("cnt0", cnt0, m_cnt0);
            check("cnt1", cnt1, m_cnt1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int cycles;
    int start_acc;

    initial begin
        step();
        check_en = 1'b1;
        rst_n = 1'b1;

        // Fill both channels, then assert reset mid-cycle.
        in_valid = 1'b1; in_select = 1'b0; in_data = 4'd3;
        step();
        in_select = 1'b1; in_data = 4'd9;
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out0_valid", out0_valid, 0);
        check("rst_out1_valid", out1_valid, 0);
        check("rst_out0_data", out0_data, 0);
        check("rst_out1_data", out1_data, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;

        // Route: first transfer on the first edge after reset release.
        in_valid = 1'b1; in_select = 1'b0; in_data = 4'd12;
        step();
        check("route_out0_valid", out0_valid, 1);
        check("route_out0_data", out0_data, 12);
        check("route_out1_valid", out1_valid, 0);
        in_select = 1'b1; in_data = 4'd10;
        step();
        check("route_out1_data", out1_data, 10);
        check("route_out0_hold", out0_data, 12);

        // Backpressure on channel 0.
        in_select = 1'b0; in_data = 4'd5;
        #1;
        check("bp_in_ready0", in_ready, 0);
        repeat (3) begin
            step();
            check("bp_out0_data", out0_data, 12);
        end
        in_valid = 1'b0; out1_ready = 1'b1;
        step();
        out1_ready = 1'b0; in_select = 1'b1;
        #1;
        check("bp_in_ready1", in_ready, 1);
        check("bp_cnt1", cnt1, 1);

        // Simultaneous drain and load on channel 0.
        out0_ready = 1'b1; in_valid = 1'b1; in_select = 1'b0; in_data = 4'd7;
        step();
        in_valid = 1'b0; out0_ready = 1'b0;
        check("sim_out0_valid", out0_valid, 1);
        check("sim_out0_data", out0_data, 7);
        check("sim_cnt0", cnt0, 1);

        // Counter wrap on channel 1 from a clean reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        out1_ready = 1'b1; in_valid = 1'b1; in_select = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 4'($urandom);
            step();
        end
        check("wrap_cnt1_255", cnt1, 255);
        in_valid = 1'b0;
        step();
        check("wrap_cnt1", cnt1, 0);
        check("wrap_cnt0", cnt0, 0);
        check("wrap_out1_valid", out1_valid, 0);
        out1_ready = 1'b0;

        // Random stream of 1000 words.
        start_acc = accepted;
        drained = 0;
        cycles = 0;
        while ((accepted - start_acc) < 1000 && cycles < 20000) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_select  = 1'($urandom);
            in_data    = 4'($urandom);
            out0_ready = 1'($urandom);
            out1_ready = 1'($urandom);
            step();
            cycles++;
        end
        check("rand_words_accepted", accepted - start_acc, 1000);
        in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (3) step();
        check("rand_words_drained", drained, 1000);
        check("rand_cnt_sum", (int'(cnt0) + int'(cnt1)) % 256, 1000 % 256);
        check("rand_out0_empty", out0_valid, 0);
        check("rand_out1_empty", out1_valid, 0);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/demux12_router.md
DEMUX12_ROUTER -- requirements
Module: demux12_router

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the payload width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of each per-channel transfer counter.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1, rising-edge clock for all state.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port in_valid, input, 1, upstream word present.
REQ-007 Port in_ready, output, 1, block can accept the upstream word this cycle.
REQ-008 Port in_data, input, WIDTH, upstream payload.
REQ-009 Port in_select, input, 1, destination channel for the upstream word (0 -> out0, 1 -> out1).
REQ-010 Port out0_valid, output, 1, channel 0 holds a word.
REQ-011 Port out0_ready, input, 1, channel 0 consumer accepts.
REQ-012 Port out0_data, output, WIDTH, channel 0 payload.
REQ-013 Port out1_valid, output, 1, channel 1 holds a word.
REQ-014 Port out1_ready, input, 1, channel 1 consumer accepts.
REQ-015 Port out1_data, output, WIDTH, channel 1 payload.
REQ-016 Port cnt0, output, CNT_W, count of completed channel 0 output transfers.
REQ-017 Port cnt1, output, CNT_W, count of completed channel 1 output transfers.

Function
REQ-018 Each channel SHALL be a one-entry holding register with two states: EMPTY (outN_valid=0) and FULL (outN_valid=1).
REQ-019 in_ready SHALL be combinational and equal to (!outS_valid || outS_ready), where S = in_select.
REQ-020 An input transfer SHALL occur on a rising edge where in_valid && in_ready.
REQ-021 On an input transfer, in_data SHALL be registered into channel S and outS_valid SHALL be 1 from the next cycle (latency 1 clock).
REQ-022 An output transfer on channel N SHALL occur on a rising edge where outN_valid && outN_ready.
REQ-023 Channel N transitions:
- EMPTY -> FULL on an input transfer to N.
- FULL -> EMPTY on an output transfer with no input transfer to N.
- FULL -> FULL with new data when an output transfer and an input transfer to N occur in the same cycle.
REQ-024 A channel not addressed by in_select SHALL keep its data and valid unchanged, except for its own output transfer.
REQ-025 outN_data SHALL be stable while outN_valid=1 and outN_ready=0.
REQ-026 in_data and in_select SHALL be sampled only on an input transfer; changes while in_ready=0 SHALL have no effect.
REQ-027 Both channels MAY complete output transfers in the same cycle, independently.
REQ-028 cntN SHALL increment by 1 on each channel N output transfer and wrap from 2^CNT_W-1 to 0.
REQ-029 Output valid signals SHALL NOT depend combinationally on any ready input.
REQ-030 A word SHALL never be dropped or duplicated: each input transfer produces exactly one output transfer on its selected channel.

Reset
REQ-031 While rst_n=0, the block SHALL force out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, cnt0=0 and cnt1=0, independent of clk.
REQ-032 Words held when reset asserts mid-operation SHALL be discarded.
REQ-033 in_ready SHALL be 1 during and after reset (both channels EMPTY), per REQ-019.
REQ-034 The first input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-035 Reset: rst_n=0 with both channels FULL -> all outputs and counters 0 immediately, without waiting for a clock edge.
REQ-036 Route: in_data=12, in_select=0, out0_ready=0 -> next cycle out0_valid=1, out0_data=12, out1_valid=0; then in_data=10, in_select=1 -> out1_data=10, out0_data still 12.
REQ-037 Backpressure: channel 0 FULL, out0_ready=0, in_select=0 -> in_ready=0; change in_data to 5 for 3 cycles -> out0_data stays 12; with in_select=1 in the same state -> in_ready=1.
REQ-038 Simultaneous: channel 0 FULL with 12, out0_ready=1, in_valid=1, in_select=0, in_data=7 -> next cycle out0_valid=1, out0_data=7, cnt0 increments by 1.
REQ-039 Counter wrap: perform 256 channel 1 transfers with CNT_W=8 -> cnt1 returns to 0 and cnt0 is unchanged.
REQ-040 Random stream: 1000 words with random select and random ready on both channels -> per-channel output order equals input order, and cnt0+cnt1 equals the number of words drained.
